// File: rtl/key_debounce_multi_if.sv
// Key debouncer bus: raw pins in, polarity-normalised level and event pulses out.
interface key_debounce_multi_if #(
  parameter int unsigned KEY_N = 4
);
  logic [KEY_N-1:0] key;
  logic [KEY_N-1:0] key_level;
  logic [KEY_N-1:0] key_press;
  logic [KEY_N-1:0] key_release;
  logic [KEY_N-1:0] key_long;
  logic [KEY_N-1:0] key_rep;

  // Board/consumer side: drives pins, observes events.
  modport master (
    output key,
    input  key_level, key_press, key_release, key_long, key_rep
  );

  // Debouncer side.
  modport slave (
    input  key,
    output key_level, key_press, key_release, key_long, key_rep
  );
endinterface

// File: rtl/key_debounce_multi.sv
// Multi-channel push-button debouncer: 2-FF sync, per-channel debounce window,
// press/release pulses, long-press pulse and optional auto-repeat.
module key_debounce_multi #(
  parameter int unsigned KEY_N      = 4,
  parameter int unsigned ACTIVE_LOW = 1,
  parameter int unsigned CNT_MAX    = 1_000_000,
  parameter int unsigned LONG_MAX   = 50_000_000,
  parameter int unsigned REP_MAX    = 10_000_000
) (
  input logic                 clk,
  input logic                 rstn,
  key_debounce_multi_if.slave bus
);

  localparam int unsigned CNT_W    = $clog2(CNT_MAX);
  localparam int unsigned HOLD_MAX = (LONG_MAX > REP_MAX) ? LONG_MAX : REP_MAX;
  localparam int unsigned HOLD_W   = $clog2(HOLD_MAX);

  localparam logic [CNT_W-1:0]  CntLast  = CNT_W'(CNT_MAX - 1);
  localparam logic [HOLD_W-1:0] LongLast = HOLD_W'(LONG_MAX - 1);
  localparam logic [HOLD_W-1:0] RepLast  = HOLD_W'((REP_MAX > 0) ? REP_MAX - 1 : 0);
  // Pin level of a released key.
  localparam logic [KEY_N-1:0]  IdlePin  = {KEY_N{(ACTIVE_LOW != 0)}};

  typedef enum logic [1:0] {StIdle, StHeld, StLong} phase_e;

  logic [KEY_N-1:0]  s0_q, s1_q, p;
  logic [KEY_N-1:0]  level_q, level_d;
  logic [KEY_N-1:0]  press_q, press_d;
  logic [KEY_N-1:0]  release_q, release_d;
  logic [KEY_N-1:0]  long_q, long_d;
  logic [KEY_N-1:0]  rep_q, rep_d;
  logic [CNT_W-1:0]  cnt_q [KEY_N];
  logic [CNT_W-1:0]  cnt_d [KEY_N];
  logic [HOLD_W-1:0] hold_q [KEY_N];
  logic [HOLD_W-1:0] hold_d [KEY_N];
  phase_e            state_q [KEY_N];
  phase_e            state_d [KEY_N];

  // Polarity-normalised synchronised pins: 1 = pressed.
  assign p = (ACTIVE_LOW != 0) ? ~s1_q : s1_q;

  // Next-state: debounce window, edge pulses and hold-phase FSM per channel.
  always_comb begin
    level_d   = level_q;
    press_d   = '0;
    release_d = '0;
    long_d    = '0;
    rep_d     = '0;
    for (int i = 0; i < KEY_N; i++) begin
      cnt_d[i]   = '0;
      hold_d[i]  = hold_q[i];
      state_d[i] = state_q[i];

      // Any sample agreeing with the level restarts the window.
      if (p[i] != level_q[i]) begin
        if (cnt_q[i] == CntLast) begin
          level_d[i]   = p[i];
          press_d[i]   = p[i];
          release_d[i] = ~p[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end

      // Release wins over a long/repeat due on the same edge.
      unique case (state_q[i])
        StIdle: begin
          hold_d[i] = '0;
          if (press_d[i]) state_d[i] = StHeld;
        end
        StHeld: begin
          if (release_d[i]) begin
            state_d[i] = StIdle;
            hold_d[i]  = '0;
          end else if (hold_q[i] == LongLast) begin
            long_d[i]  = 1'b1;
            state_d[i] = StLong;
            hold_d[i]  = '0;
          end else begin
            hold_d[i] = hold_q[i] + HOLD_W'(1);
          end
        end
        StLong: begin
          if (release_d[i]) begin
            state_d[i] = StIdle;
            hold_d[i]  = '0;
          end else if (REP_MAX != 0) begin
            if (hold_q[i] == RepLast) begin
              rep_d[i]  = 1'b1;
              hold_d[i] = '0;
            end else begin
              hold_d[i] = hold_q[i] + HOLD_W'(1);
            end
          end
        end
        default: begin
          state_d[i] = StIdle;
          hold_d[i]  = '0;
        end
      endcase
    end
  end

  // State registers; async reset parks synchronisers at the released pin level.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s0_q      <= IdlePin;
      s1_q      <= IdlePin;
      level_q   <= '0;
      press_q   <= '0;
      release_q <= '0;
      long_q    <= '0;
      rep_q     <= '0;
      for (int i = 0; i < KEY_N; i++) begin
        cnt_q[i]   <= '0;
        hold_q[i]  <= '0;
        state_q[i] <= StIdle;
      end
    end else begin
      s0_q      <= bus.key;
      s1_q      <= s0_q;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
      long_q    <= long_d;
      rep_q     <= rep_d;
      for (int i = 0; i < KEY_N; i++) begin
        cnt_q[i]   <= cnt_d[i];
        hold_q[i]  <= hold_d[i];
        state_q[i] <= state_d[i];
      end
    end
  end

  assign bus.key_level   = level_q;
  assign bus.key_press   = press_q;
  assign bus.key_release = release_q;
  assign bus.key_long    = long_q;
  assign bus.key_rep     = rep_q;

endmodule

// File: tb/tb_key_debounce_multi.sv
// Directed bench for key_debounce_multi (CNT_MAX=8, LONG_MAX=20, REP_MAX=5, active-low pins).
module tb_key_debounce_multi;

  localparam int unsigned KeyN    = 4;
  localparam int unsigned CntMax  = 8;
  localparam int unsigned LongMax = 20;
  localparam int unsigned RepMax  = 5;

  logic        clk  = 1'b0;
  logic        rstn = 1'b0;
  int unsigned checks = 0;
  int unsigned errors = 0;
  logic        acc_a, acc_b, acc_c;

  key_debounce_multi_if #(.KEY_N(KeyN)) bus ();

  key_debounce_multi #(
    .KEY_N     (KeyN),
    .ACTIVE_LOW(1),
    .CNT_MAX   (CntMax),
    .LONG_MAX  (LongMax),
    .REP_MAX   (RepMax)
  ) dut (
    .clk (clk),
    .rstn(rstn),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic ncyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    bus.key = 4'hF;
    ncyc(3);
    chk("rst_level",   32'(bus.key_level),   32'h0);
    chk("rst_press",   32'(bus.key_press),   32'h0);
    chk("rst_release", 32'(bus.key_release), 32'h0);
    chk("rst_long",    32'(bus.key_long),    32'h0);
    chk("rst_rep",     32'(bus.key_rep),     32'h0);
    rstn = 1'b1;
    ncyc(4);

    // 1: clean press on key[0]; level/press after edge 9, 1-cycle pulse.
    bus.key[0] = 1'b0;
    ncyc(9);
    chk("t1_level_early", 32'(bus.key_level[0]), 32'h0);
    chk("t1_press_early", 32'(bus.key_press[0]), 32'h0);
    ncyc(1);
    chk("t1_level", 32'(bus.key_level), 32'h1);
    chk("t1_press", 32'(bus.key_press), 32'h1);
    ncyc(1);
    chk("t1_press_width", 32'(bus.key_press[0]), 32'h0);
    chk("t1_level_hold",  32'(bus.key_level[0]), 32'h1);
    bus.key[0] = 1'b1;
    acc_a = 1'b0;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      if (k == 9 || k == 10 || k == 11)
        chk("t1_release", 32'(bus.key_release[0]), 32'(k == 10));
      acc_a |= bus.key_long[0] | bus.key_rep[0];
    end
    chk("t1_no_long", 32'(acc_a), 32'h0);

    // 2: key[1] bounces every 3 cycles; never settles long enough.
    acc_a = 1'b0; acc_b = 1'b0; acc_c = 1'b0;
    for (int i = 0; i < 60; i++) begin
      bus.key[1] = (i >= 40) ? 1'b1 : (((i / 3) % 2) == 1);
      @(negedge clk);
      acc_a |= bus.key_level[1];
      acc_b |= bus.key_press[1];
      acc_c |= bus.key_release[1];
    end
    chk("t2_level",   32'(acc_a), 32'h0);
    chk("t2_press",   32'(acc_b), 32'h0);
    chk("t2_release", 32'(acc_c), 32'h0);

    // 3: key[2] held; long at press+20, repeats every 5 after that.
    bus.key[2] = 1'b0;
    ncyc(10);
    chk("t3_press", 32'(bus.key_press), 32'h4);
    for (int k = 1; k <= 52; k++) begin
      @(negedge clk);
      chk("t3_long", 32'(bus.key_long[2]), 32'(k == 20));
      chk("t3_rep",  32'(bus.key_rep[2]),  32'(k >= 25 && ((k - 20) % 5) == 0));
    end
    chk("t3_level", 32'(bus.key_level[2]), 32'h1);

    // 6: async reset mid-repeat with key[2] still held.
    #2 rstn = 1'b0;
    #1;
    chk("t6_async_level", 32'(bus.key_level), 32'h0);
    chk("t6_async_pulse",
        32'(bus.key_press | bus.key_release | bus.key_long | bus.key_rep), 32'h0);
    @(negedge clk);
    rstn = 1'b1;
    acc_a = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      acc_a |= bus.key_release[2];
      if (k == 9)  chk("t6_press_early", 32'(bus.key_press[2]), 32'h0);
      if (k == 10) chk("t6_press",       32'(bus.key_press[2]), 32'h1);
    end
    chk("t6_no_release", 32'(acc_a), 32'h0);
    bus.key[2] = 1'b1;
    ncyc(15);
    chk("t6_released", 32'(bus.key_level[2]), 32'h0);

    // 4: key[3] released 10 cycles after press; release lands on the long edge.
    bus.key[3] = 1'b0;
    ncyc(10);
    chk("t4_press", 32'(bus.key_press), 32'h8);
    ncyc(10);
    bus.key[3] = 1'b1;
    acc_a = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (k >= 8 && k <= 12)
        chk("t4_release", 32'(bus.key_release[3]), 32'(k == 10));
      acc_a |= bus.key_long[3] | bus.key_rep[3];
    end
    chk("t4_no_long", 32'(acc_a), 32'h0);

    // 5: key[0] and key[3] pressed together.
    bus.key = 4'b0110;
    ncyc(9);
    chk("t5_press_early", 32'(bus.key_press), 32'h0);
    ncyc(1);
    chk("t5_press", 32'(bus.key_press), 32'h9);
    chk("t5_level", 32'(bus.key_level), 32'h9);
    ncyc(1);
    chk("t5_press_width", 32'(bus.key_press), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
